spi_cmd_master: RTL and testbench

- Synthesizable SPI command master that replaces the behavioural SPI stimulus task used in simulation.
- Accepts 32-bit command words {code[5:0], addr[9:0], data[15:0]} through a valid/ready port and buffers them in a small command FIFO.
- Serialises each word onto sck/mosi/cs_n with the established frame timing and returns the word captured on miso.
- Sits between the FPGA control logic (or bench driver) and the chip SPI slave; adds a configurable SCK divider, bit order and queueing.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_cmd_fifo.sv | 39 +++
 rtl/spi_cmd_master.sv | 111 +++++++++++
 tb/tb_spi_cmd_master.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: SPI command word field widths, chip command codes, master FSM states and bit-order helper
package spi_pkg;
  localparam int SPI_CODE_LEN = 6;
  localparam int SPI_ADDR_LEN = 10;
  localparam int SPI_DATA_LEN = 16;
  localparam int LEN_SPI = SPI_CODE_LEN + SPI_ADDR_LEN + SPI_DATA_LEN;
  localparam int IDX_W = $clog2(LEN_SPI);
  localparam logic [SPI_CODE_LEN-1:0] CMD_NOP = 6'd0;
  localparam logic [SPI_CODE_LEN-1:0] CMD_READ_REC = 6'd1;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WRITE_REC = 6'd4;
  localparam logic [SPI_CODE_LEN-1:0] CMD_AFE_RST = 6'd7;
  localparam logic [SPI_CODE_LEN-1:0] CMD_AFE_RST_REL = 6'd8;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_ELE_NP = 6'd10;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ELE_NP = 6'd11;
  localparam logic [SPI_CODE_LEN-1:0] CMD_ELE_RST = 6'd12;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ADC = 6'd19;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_CHEM_NP = 6'd20;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_CHEM_NP = 6'd21;
  localparam logic [SPI_CODE_LEN-1:0] CMD_CHEM_RST = 6'd22;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_ELE_CACHE = 6'd23;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_CHEM_CACHE = 6'd24;
  typedef enum logic [2:0] {IDLE, SHIFT_HI, SHIFT_LO, TRAIL, GAP} spi_state_t;
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] i, input logic msb);
    return msb ? IDX_W'(LEN_SPI - 1) - i : i;
  endfunction
endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous FIFO with occupancy level and synchronous flush on rst
module spi_cmd_fifo #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [W-1:0]       wr_data,
  input  logic               rd_en,
  output logic [W-1:0]       rd_data,
  output logic [$clog2(D):0] level,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign full = level == (AW+1)'(D);
  assign empty = level == '0;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rp];
  // storage array, contents need no reset
  always_ff @(posedge clk) if (do_wr) mem[wp] <= wr_data;
  // pointers wrap naturally; simultaneous read and write leave the level unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= do_wr ? wp + AW'(1) : wp;
      rp <= do_rd ? rp + AW'(1) : rp;
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: queued SPI command master; define SPI_AUTO_DUMMY_EN to append a zero frame after non-zero codes
module spi_cmd_master
  import spi_pkg::*;
#(
  parameter int SCK_DIV = 5,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                        clk_50M,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [LEN_SPI-1:0]          cmd_data,
  output logic                        rsp_valid,
  output logic [LEN_SPI-1:0]          rsp_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        sck,
  output logic                        mosi,
  output logic                        cs_n,
  input  logic                        miso
);
  localparam int CW = $clog2(SCK_DIV + 1);
  spi_state_t state;
  logic [CW-1:0] cnt;
  logic [IDX_W-1:0] bit_i;
  logic [LEN_SPI-1:0] word, cap, head;
  logic full, empty, pop, tick, dummy_pend;
  spi_cmd_fifo #(.W(LEN_SPI), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk_50M),
    .rst(rst),
    .wr_en(cmd_valid),
    .wr_data(cmd_data),
    .rd_en(pop),
    .rd_data(head),
    .level(fifo_level),
    .full(full),
    .empty(empty)
  );
`ifndef SPI_AUTO_DUMMY_EN
  assign dummy_pend = 1'b0;
`endif
  assign cmd_ready = !full;
  assign tick = cnt == CW'(SCK_DIV - 1);
  assign pop = state == IDLE && !empty && !dummy_pend;
  assign busy = state != IDLE || fifo_level != '0 || dummy_pend;
  // frame sequencer: every phase lasts SCK_DIV cycles; mosi only moves when sck rises
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_i <= '0;
      word <= '0;
      cap <= '0;
      sck <= 1'b1;
      cs_n <= 1'b1;
      mosi <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
`ifdef SPI_AUTO_DUMMY_EN
      dummy_pend <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      cnt <= tick ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pop || dummy_pend) begin
            word <= dummy_pend ? '0 : head;
            mosi <= dummy_pend ? 1'b0 : head[bit_pos('0, MSB_FIRST)];
            bit_i <= '0;
            cs_n <= 1'b0;
            sck <= 1'b1;
            state <= SHIFT_HI;
`ifdef SPI_AUTO_DUMMY_EN
            dummy_pend <= 1'b0;
`endif
          end
        end
        SHIFT_HI: if (tick) begin
          sck <= 1'b0;
          cap[bit_pos(bit_i, MSB_FIRST)] <= miso;
          state <= SHIFT_LO;
        end
        SHIFT_LO: if (tick) begin
          sck <= 1'b1;
          if (bit_i != IDX_W'(LEN_SPI - 1)) begin
            bit_i <= bit_i + IDX_W'(1);
            mosi <= word[bit_pos(bit_i + IDX_W'(1), MSB_FIRST)];
            state <= SHIFT_HI;
          end else begin
            mosi <= 1'b0;
            state <= TRAIL;
          end
        end
        TRAIL: if (tick) begin
          cs_n <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_data <= cap;
          state <= GAP;
`ifdef SPI_AUTO_DUMMY_EN
          dummy_pend <= word[LEN_SPI-1 -: SPI_CODE_LEN] != '0;
`endif
        end
        GAP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: directed checks of frame timing, bit order, queueing, reset abort and auto dummy frames
module tb_spi_cmd_master;
  import spi_pkg::*;
  localparam int LIM = 20000;
`ifdef SPI_AUTO_DUMMY_EN
  localparam int DUMMY = 1;
`else
  localparam int DUMMY = 0;
`endif
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic [1:0] rst, cmd_valid, cmd_ready, rsp_valid, busy, sck, mosi, cs_n;
  logic [31:0] cmd_data [2];
  logic [31:0] rsp_data [2];
  logic [2:0] lvl [2];
  logic [31:0] slv [2];
  int n_cmp = 0, n_bad = 0;
  int f0, r0;
  // instance 0: SCK_DIV=5, LSB first; instance 1: SCK_DIV=1, MSB first
  for (genvar g = 0; g < 2; g++) begin : blk
    logic miso = 1'b0;
    int cyc = 0, low_cnt = 0, low_last = 0, gap_cnt = 0, gap_min = 1000;
    int falls = 0, falls_last = 0, frames = 0, rsps = 0, period = 0, fall_cyc = 0, k = 0;
    logic [31:0] cap = '0, rsp_last = '0;
    logic [31:0] log_w [16];
    bit pcs = 1'b1, psck = 1'b1;
    spi_cmd_master #(.SCK_DIV(g ? 1 : 5), .FIFO_DEPTH(4), .MSB_FIRST(g == 1)) dut (
      .clk_50M(clk),
      .rst(rst[g]),
      .cmd_valid(cmd_valid[g]),
      .cmd_ready(cmd_ready[g]),
      .cmd_data(cmd_data[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_data(rsp_data[g]),
      .busy(busy[g]),
      .fifo_level(lvl[g]),
      .sck(sck[g]),
      .mosi(mosi[g]),
      .cs_n(cs_n[g]),
      .miso(miso)
    );
    // bus monitor and slave model: captures mosi at sck falls, shifts slv out, advancing on sck rises
    always @(negedge clk) begin
      cyc++;
      if (rsp_valid[g]) begin
        rsps++;
        rsp_last = rsp_data[g];
      end
      if (pcs && !cs_n[g]) begin
        if (frames > 0 && gap_cnt < gap_min) gap_min = gap_cnt;
        low_cnt = 0;
        falls = 0;
        k = 0;
        cap = '0;
        miso = slv[g][g ? 31 : 0];
      end
      if (!pcs && cs_n[g]) begin
        low_last = low_cnt;
        falls_last = falls;
        log_w[frames % 16] = cap;
        frames++;
        gap_cnt = 0;
      end
      if (cs_n[g]) gap_cnt++;
      else low_cnt++;
      if (!cs_n[g] && psck && !sck[g]) begin
        if (falls > 0) period = cyc - fall_cyc;
        fall_cyc = cyc;
        if (falls < 32) cap[g ? 31 - falls : falls] = mosi[g];
        falls++;
      end
      if (!cs_n[g] && !psck && sck[g]) begin
        k++;
        miso = k < 32 ? slv[g][g ? 31 - k : k] : 1'b0;
      end
      pcs = cs_n[g];
      psck = sck[g];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int j, input logic [31:0] w);
    int t = 0;
    cmd_valid[j] = 1'b1;
    cmd_data[j] = w;
    while (!cmd_ready[j] && t < LIM) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cmd_valid[j] = 1'b0;
    chk("push_wait", 32'(t < LIM), 32'd1);
  endtask
  task automatic wait_idle(input int j);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy[j] && t < LIM);
    chk("idle_wait", 32'(t < LIM), 32'd1);
  endtask
  initial begin
    int t;
    rst = 2'b11;
    cmd_valid = 2'b00;
    cmd_data[0] = '0;
    cmd_data[1] = '0;
    slv[0] = '0;
    slv[1] = '0;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    for (int j = 0; j < 2; j++) begin
      chk("rst_pins", 32'({sck[j], cs_n[j], mosi[j], rsp_valid[j], busy[j], cmd_ready[j]}), 32'b110001);
      chk("rst_level", 32'(lvl[j]), 32'd0);
      chk("rst_rsp", rsp_data[j], 32'd0);
    end
    f0 = blk[0].frames;
    r0 = blk[0].rsps;
    slv[0] = 32'hA5A5_0F0F;
    push(0, 32'h2004_0000);
    wait_idle(0);
    chk("t1_frames", 32'(blk[0].frames - f0), 32'(1 + DUMMY));
    chk("t1_rsps", 32'(blk[0].rsps - r0), 32'(1 + DUMMY));
    chk("t1_cs_low", 32'(blk[0].low_last), 32'd325);
    chk("t1_falls", 32'(blk[0].falls_last), 32'd32);
    chk("t1_period", 32'(blk[0].period), 32'd10);
    chk("t1_mosi", blk[0].log_w[f0 % 16], 32'h2004_0000);
    chk("t1_rsp", blk[0].rsp_last, 32'hA5A5_0F0F);
    f0 = blk[1].frames;
    slv[1] = 32'hA5A5_0F0F;
    push(1, 32'h0012_3456);
    wait_idle(1);
    chk("t2_frames", 32'(blk[1].frames - f0), 32'd1);
    chk("t2_cs_low", 32'(blk[1].low_last), 32'd65);
    chk("t2_falls", 32'(blk[1].falls_last), 32'd32);
    chk("t2_period", 32'(blk[1].period), 32'd2);
    chk("t2_mosi", blk[1].log_w[f0 % 16], 32'h0012_3456);
    chk("t2_rsp", blk[1].rsp_last, 32'hA5A5_0F0F);
    f0 = blk[0].frames;
    for (int i = 0; i < 5; i++) push(0, 32'h0001_C0DE + 32'(i) * 32'h0001_0101);
    chk("t3_level_full", 32'(lvl[0]), 32'd4);
    chk("t3_ready_low", 32'(cmd_ready[0]), 32'd0);
    cmd_valid[0] = 1'b1;
    cmd_data[0] = 32'h0001_C0DE + 32'd5 * 32'h0001_0101;
    repeat (20) @(negedge clk);
    chk("t3_full_hold", 32'(lvl[0]), 32'd4);
    push(0, 32'h0001_C0DE + 32'd5 * 32'h0001_0101);
    wait_idle(0);
    chk("t3_frames", 32'(blk[0].frames - f0), 32'd6);
    for (int i = 0; i < 6; i++) chk("t3_order", blk[0].log_w[(f0 + i) % 16], 32'h0001_C0DE + 32'(i) * 32'h0001_0101);
    push(0, 32'h03FF_FFFF);
    push(0, 32'h0000_5555);
    @(negedge clk);
    t = 0;
    while (blk[0].falls < 17 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("t4_reach_bit17", 32'(t < LIM), 32'd1);
    r0 = blk[0].rsps;
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t4_pins", 32'({sck[0], cs_n[0], mosi[0], rsp_valid[0], busy[0]}), 32'b11000);
    chk("t4_level", 32'(lvl[0]), 32'd0);
    rst[0] = 1'b0;
    repeat (700) @(negedge clk);
    chk("t4_no_rsp", 32'(blk[0].rsps - r0), 32'd0);
    slv[0] = 32'h1357_9BDF;
    f0 = blk[0].frames;
    push(0, 32'h0000_1234);
    wait_idle(0);
    chk("t4_mosi", blk[0].log_w[f0 % 16], 32'h0000_1234);
    chk("t4_rsp", blk[0].rsp_last, 32'h1357_9BDF);
    chk("t4_cs_low", 32'(blk[0].low_last), 32'd325);
    f0 = blk[1].frames;
    push(1, 32'h00AB_0000);
    chk("t5_level0", 32'(lvl[1]), 32'd1);
    push(1, 32'h00AB_1111);
    chk("t5_pushpop", 32'(lvl[1]), 32'd1);
    push(1, 32'h00AB_2222);
    chk("t5_level2", 32'(lvl[1]), 32'd2);
    wait_idle(1);
    chk("t5_frames", 32'(blk[1].frames - f0), 32'd3);
    for (int i = 0; i < 3; i++) chk("t5_order", blk[1].log_w[(f0 + i) % 16], 32'h00AB_0000 + 32'(i) * 32'h0000_1111);
    chk("t5_cs_low", 32'(blk[1].low_last), 32'd65);
    chk("t5_gap", 32'(blk[1].gap_min), 32'd2);
    f0 = blk[0].frames;
    r0 = blk[0].rsps;
    push(0, 32'h4C0B_0000);
    wait_idle(0);
    chk("t6_frames", 32'(blk[0].frames - f0), 32'(1 + DUMMY));
    chk("t6_rsps", 32'(blk[0].rsps - r0), 32'(1 + DUMMY));
    chk("t6_first", blk[0].log_w[f0 % 16], 32'h4C0B_0000);
    chk("t6_last", blk[0].log_w[(f0 + DUMMY) % 16], DUMMY ? 32'h0 : 32'h4C0B_0000);
    chk("t6_gap_min", 32'(blk[0].gap_min), 32'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
